mul_pipeline: RTL and testbench
===============================

MUL_PIPELINE -- requirements
Module: mul_pipeline

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default params_pkg::DATA_WIDTH (32), operand/result width.
REQ-002 SHALL have parameter REGISTER_WIDTH, default params_pkg::REGISTER_WIDTH (5), destination register index width.
REQ-003 SHALL have parameter ADDR_WIDTH, default params_pkg::ADDR_WIDTH, PC width, used for debug tracking only.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have ports:
  clk_i  in  1  clock, rising edge
  rst_i  in  1  asynchronous active-high reset
  valid_i  in  1  multiply issued by decode this cycle (decode ex_valid_o)
  wr_reg_i  in  REGISTER_WIDTH  destination register of issued multiply
  rs1_data_i  in  DATA_WIDTH  multiplicand, already bypassed by decode
  rs2_data_i  in  DATA_WIDTH  multiplier, already bypassed by decode
  pc_i  in  ADDR_WIDTH  PC of issued multiply (debug)
  ex1_valid_o..ex5_valid_o  out  1 each  stage N holds a live multiply
  ex1_wr_reg_o..ex5_wr_reg_o  out  REGISTER_WIDTH each  destination register in stage N
  ex5_result_o  out  DATA_WIDTH  final product, bypass source for decode
  wb_is_next_cycle_o  out  1  multiply will occupy writeback next cycle
  wb_valid_o  out  1  writeback request this cycle
  wb_reg_o  out  REGISTER_WIDTH  writeback destination
  wb_data_o  out  DATA_WIDTH  writeback data
  busy_o  out  1  any of ex1..ex4 valid
  debug_ex5_pc_o  out  ADDR_WIDTH  PC in ex5 (omitted under SYNTHESIS)

Function
REQ-006 SHALL be a 5-stage shift pipeline that advances every cycle; no stall or back-pressure input.
REQ-007 SHALL capture valid_i, wr_reg_i, operands and pc_i into ex1 on every rising edge; when valid_i=0, ex1_valid_o SHALL become 0.
REQ-008 SHALL move stage N contents (valid, wr_reg, accumulator, operands, pc) into stage N+1 every edge, N=1..4.
REQ-009 SHALL compute product as four 8-bit multiplier slices: ex1 acc = rs1*rs2[7:0]; ex2 acc += (rs1*rs2[15:8])<<8; ex3 acc += (rs1*rs2[23:16])<<16; ex4 acc += (rs1*rs2[31:24])<<24; ex5 registers final acc.
REQ-010 SHALL keep only the low DATA_WIDTH bits of every partial sum and of the result (RISC-V MUL semantics, silent wrap, signedness irrelevant).
REQ-011 SHALL present the result at ex5_result_o with ex5_valid_o=1 exactly 5 edges after the edge sampling valid_i=1.
REQ-012 SHALL drive wb_valid_o=ex5_valid_o, wb_reg_o=ex5_wr_reg_o, wb_data_o=ex5_result_o combinationally.
REQ-013 SHALL drive wb_is_next_cycle_o=ex4_valid_o combinationally.
REQ-014 SHALL drive busy_o = ex1_valid_o|ex2_valid_o|ex3_valid_o|ex4_valid_o combinationally.
REQ-015 SHALL accept back-to-back issues (one per cycle), each completing independently in order.
REQ-016 SHALL treat wr_reg_i=0 like any register; writeback suppression of x0 is the register file's job.
REQ-017 SHALL advance stage data when valid=0 without affecting any valid output.

Reset
REQ-018 SHALL on rst_i=1 immediately clear all ex1..ex5 valids, wr_regs, accumulators, operands and debug PCs to 0, independent of clk_i.
REQ-019 SHALL therefore hold every output at 0 during reset, including wb_valid_o, wb_is_next_cycle_o, busy_o.
REQ-020 SHALL discard all in-flight multiplies on reset mid-operation; none SHALL appear at ex5 after reset release.
REQ-021 SHALL accept a new valid_i on the first rising edge after rst_i deasserts.

Verification
REQ-022 Issue 7*6, rd=3 -> ex1..ex5_valid_o pulse on successive cycles; after 5th edge ex5_result_o=42, wb_valid_o=1, wb_reg_o=3; wb_is_next_cycle_o=1 the cycle before.
REQ-023 Issue 0xFFFFFFFF*0xFFFFFFFF -> wb_data_o=0x00000001; 0x80000000*2 -> 0x00000000 (wrap).
REQ-024 Issue 0x12345678*0x9ABCDEF0 then 3*5 on consecutive cycles, rd=1 then 2 -> wb_data_o 0x242D2080 then 15 on consecutive cycles, rd 1 then 2.
REQ-025 Issue 5*5, assert rst_i asynchronously while in ex3 -> all outputs 0 immediately; no wb_valid_o in following 10 cycles.
REQ-026 Issue one multiply, then idle -> busy_o=1 for exactly 4 cycles, then 0 while ex5_valid_o=1.

Source files
------------

// File: rtl/mul_pipeline.sv
// rtl/mul_pipeline.sv - five-stage shift-pipelined 32-bit multiplier (low-word product)
// Each of ex1..ex4 folds one 8-bit multiplier slice into the accumulator; ex5 holds the result.
module mul_pipeline #(
    parameter int DATA_WIDTH     = 32,
    parameter int REGISTER_WIDTH = 5,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      valid_i,
    input  logic [REGISTER_WIDTH-1:0] wr_reg_i,
    input  logic [DATA_WIDTH-1:0]     rs1_data_i,
    input  logic [DATA_WIDTH-1:0]     rs2_data_i,
    input  logic [ADDR_WIDTH-1:0]     pc_i,
    output logic                      ex1_valid_o,
    output logic                      ex2_valid_o,
    output logic                      ex3_valid_o,
    output logic                      ex4_valid_o,
    output logic                      ex5_valid_o,
    output logic [REGISTER_WIDTH-1:0] ex1_wr_reg_o,
    output logic [REGISTER_WIDTH-1:0] ex2_wr_reg_o,
    output logic [REGISTER_WIDTH-1:0] ex3_wr_reg_o,
    output logic [REGISTER_WIDTH-1:0] ex4_wr_reg_o,
    output logic [REGISTER_WIDTH-1:0] ex5_wr_reg_o,
    output logic [DATA_WIDTH-1:0]     ex5_result_o,
    output logic                      wb_is_next_cycle_o,
    output logic                      wb_valid_o,
    output logic [REGISTER_WIDTH-1:0] wb_reg_o,
    output logic [DATA_WIDTH-1:0]     wb_data_o,
`ifndef SYNTHESIS
    output logic [ADDR_WIDTH-1:0]     debug_ex5_pc_o,
`endif
    output logic                      busy_o
);

    localparam int STAGES = 5;

    logic [STAGES:1]           valid;
    logic [REGISTER_WIDTH-1:0] wr_reg [1:STAGES];
    logic [DATA_WIDTH-1:0]     acc    [1:STAGES];
    logic [DATA_WIDTH-1:0]     acc_d  [1:STAGES];
    // Operands are only needed while a slice remains to be folded (through ex3).
    logic [DATA_WIDTH-1:0]     rs1    [1:3];
    logic [DATA_WIDTH-1:0]     rs2    [1:3];

    // Partial product of slice k, truncated to DATA_WIDTH bits.
    function automatic logic [DATA_WIDTH-1:0] partial(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b,
        input int                    k
    );
        logic [DATA_WIDTH-1:0] s;
        s      = '0;
        s[7:0] = b[8*k +: 8];
        return (a * s) << (8 * k);
    endfunction

    always_comb begin
        acc_d[1] = partial(rs1_data_i, rs2_data_i, 0);
        acc_d[2] = acc[1] + partial(rs1[1], rs2[1], 1);
        acc_d[3] = acc[2] + partial(rs1[2], rs2[2], 2);
        acc_d[4] = acc[3] + partial(rs1[3], rs2[3], 3);
        acc_d[5] = acc[4];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid <= '0;
            for (int i = 1; i <= STAGES; i++) begin
                wr_reg[i] <= '0;
                acc[i]    <= '0;
            end
            for (int i = 1; i <= 3; i++) begin
                rs1[i] <= '0;
                rs2[i] <= '0;
            end
        end else begin
            valid     <= {valid[STAGES-1:1], valid_i};
            wr_reg[1] <= wr_reg_i;
            rs1[1]    <= rs1_data_i;
            rs2[1]    <= rs2_data_i;
            for (int i = 2; i <= STAGES; i++) begin
                wr_reg[i] <= wr_reg[i-1];
            end
            for (int i = 2; i <= 3; i++) begin
                rs1[i] <= rs1[i-1];
                rs2[i] <= rs2[i-1];
            end
            for (int i = 1; i <= STAGES; i++) begin
                acc[i] <= acc_d[i];
            end
        end
    end

`ifndef SYNTHESIS
    logic [ADDR_WIDTH-1:0] pc [1:STAGES];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 1; i <= STAGES; i++) begin
                pc[i] <= '0;
            end
        end else begin
            pc[1] <= pc_i;
            for (int i = 2; i <= STAGES; i++) begin
                pc[i] <= pc[i-1];
            end
        end
    end

    assign debug_ex5_pc_o = pc[5];
`else
    logic unused_pc;
    assign unused_pc = ^pc_i;
`endif

    assign ex1_valid_o  = valid[1];
    assign ex2_valid_o  = valid[2];
    assign ex3_valid_o  = valid[3];
    assign ex4_valid_o  = valid[4];
    assign ex5_valid_o  = valid[5];
    assign ex1_wr_reg_o = wr_reg[1];
    assign ex2_wr_reg_o = wr_reg[2];
    assign ex3_wr_reg_o = wr_reg[3];
    assign ex4_wr_reg_o = wr_reg[4];
    assign ex5_wr_reg_o = wr_reg[5];
    assign ex5_result_o = acc[5];

    assign wb_valid_o         = valid[5];
    assign wb_reg_o           = wr_reg[5];
    assign wb_data_o          = acc[5];
    assign wb_is_next_cycle_o = valid[4];
    assign busy_o             = |valid[4:1];

endmodule

// File: tb/tb_mul_pipeline.sv
// tb/tb_mul_pipeline.sv - directed self-checking bench for mul_pipeline
module tb_mul_pipeline;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [4:0]  wr_reg_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic [31:0] pc_i;
    logic        ex1_valid_o, ex2_valid_o, ex3_valid_o, ex4_valid_o, ex5_valid_o;
    logic [4:0]  ex1_wr_reg_o, ex2_wr_reg_o, ex3_wr_reg_o, ex4_wr_reg_o, ex5_wr_reg_o;
    logic [31:0] ex5_result_o;
    logic        wb_is_next_cycle_o;
    logic        wb_valid_o;
    logic [4:0]  wb_reg_o;
    logic [31:0] wb_data_o;
    logic [31:0] debug_ex5_pc_o;
    logic        busy_o;

    int n_checks = 0;
    int n_pass   = 0;

    mul_pipeline dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .valid_i            (valid_i),
        .wr_reg_i           (wr_reg_i),
        .rs1_data_i         (rs1_data_i),
        .rs2_data_i         (rs2_data_i),
        .pc_i               (pc_i),
        .ex1_valid_o        (ex1_valid_o),
        .ex2_valid_o        (ex2_valid_o),
        .ex3_valid_o        (ex3_valid_o),
        .ex4_valid_o        (ex4_valid_o),
        .ex5_valid_o        (ex5_valid_o),
        .ex1_wr_reg_o       (ex1_wr_reg_o),
        .ex2_wr_reg_o       (ex2_wr_reg_o),
        .ex3_wr_reg_o       (ex3_wr_reg_o),
        .ex4_wr_reg_o       (ex4_wr_reg_o),
        .ex5_wr_reg_o       (ex5_wr_reg_o),
        .ex5_result_o       (ex5_result_o),
        .wb_is_next_cycle_o (wb_is_next_cycle_o),
        .wb_valid_o         (wb_valid_o),
        .wb_reg_o           (wb_reg_o),
        .wb_data_o          (wb_data_o),
        .debug_ex5_pc_o     (debug_ex5_pc_o),
        .busy_o             (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] pc);
        valid_i    = 1'b1;
        rs1_data_i = a;
        rs2_data_i = b;
        wr_reg_i   = rd;
        pc_i       = pc;
    endtask

    task automatic idle;
        valid_i    = 1'b0;
        rs1_data_i = 32'hDEAD_BEEF;
        rs2_data_i = 32'hCAFE_F00D;
        wr_reg_i   = 5'd31;
        pc_i       = 32'h0;
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valids"}, {ex5_valid_o, ex4_valid_o, ex3_valid_o, ex2_valid_o, ex1_valid_o}, 0);
        check({tag, "_wb"}, {wb_valid_o, wb_is_next_cycle_o, busy_o, wb_reg_o, wb_data_o}, 0);
        check({tag, "_ex5_result"}, ex5_result_o, 0);
        check({tag, "_pc"}, debug_ex5_pc_o, 0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(negedge clk);
        check_all_zero("reset");

        // 7*6 issued on the first edge after reset release; valid walks one stage per cycle.
        rst = 1'b0;
        issue(32'd7, 32'd6, 5'd3, 32'h0000_0100);
        for (int n = 1; n <= 5; n++) begin
            step();
            if (n == 1) idle();
            check($sformatf("walk_valids_%0d", n),
                  {ex5_valid_o, ex4_valid_o, ex3_valid_o, ex2_valid_o, ex1_valid_o}, 5'b1 << (n - 1));
            check($sformatf("walk_busy_%0d", n), busy_o, n <= 4);
            check($sformatf("walk_wb_next_%0d", n), wb_is_next_cycle_o, n == 4);
        end
        check("walk_result", ex5_result_o, 42);
        check("walk_wb", {wb_valid_o, wb_reg_o, wb_data_o}, {1'b1, 5'd3, 32'd42});
        check("walk_pc", debug_ex5_pc_o, 32'h0000_0100);
        step();
        check("walk_drain", {wb_valid_o, busy_o}, 0);

        // Wrapping products, back to back.
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'h200);
        step();
        issue(32'h8000_0000, 32'd2, 5'd31, 32'h204);
        step();
        idle();
        repeat (3) step();
        check("wrap_ff", {wb_valid_o, wb_reg_o, wb_data_o}, {1'b1, 5'd0, 32'h0000_0001});
        step();
        check("wrap_80", {wb_valid_o, wb_reg_o, wb_data_o}, {1'b1, 5'd31, 32'h0000_0000});
        step();
        check("wrap_drain", wb_valid_o, 0);

        // Mixed-operand pair on consecutive cycles.
        issue(32'h1234_5678, 32'h9ABC_DEF0, 5'd1, 32'h300);
        step();
        issue(32'd3, 32'd5, 5'd2, 32'h304);
        step();
        idle();
        check("pair_ex2_reg", {ex2_wr_reg_o, ex1_wr_reg_o}, {5'd1, 5'd2});
        repeat (3) step();
        check("pair_first", {wb_valid_o, wb_reg_o, wb_data_o}, {1'b1, 5'd1, 32'h242D_2080});
        check("pair_first_pc", debug_ex5_pc_o, 32'h300);
        step();
        check("pair_second", {wb_valid_o, wb_reg_o, wb_data_o}, {1'b1, 5'd2, 32'd15});

        // Every slice contributes: 0x01010101 * 0x04030201.
        issue(32'h0101_0101, 32'h0403_0201, 5'd7, 32'h400);
        step();
        idle();
        repeat (4) step();
        check("slices", wb_data_o, 32'h0A06_0301);

        // Asynchronous reset while 5*5 sits in ex3.
        issue(32'd5, 32'd5, 5'd9, 32'h500);
        step();
        idle();
        step();
        step();
        check("pre_rst_ex3", {ex3_valid_o, ex3_wr_reg_o}, {1'b1, 5'd9});
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 10; n++) begin
            step();
            check($sformatf("post_rst_wb_%0d", n), wb_valid_o, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
